// File: rtl/exp_rom_pkg.sv
// Shared types and constants for the ROM download loader: FSM states,
// the boot-image slot-to-page table and the extension character decoder.
package exp_rom_pkg;

  localparam logic [8:0]  MF2_PAGE   = 9'h1FF;
  localparam logic [8:0]  BAD_PAGE   = 9'h1EE;
  localparam int unsigned BOOT_PAGES = 4;

  typedef enum logic [1:0] {IDLE, PEND, WR0, WR1} state_e;

  // 16K slot n of each bank of the boot image lands on this SDRAM page
  localparam logic [8:0] BOOT_SLOT_PAGE [BOOT_PAGES] = '{9'h000, 9'h100, 9'h107, MF2_PAGE};

  // Returns {valid, nibble} for an upper-case ASCII hex digit
  function automatic logic [4:0] ext_char_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= "0" && c <= "9") begin
      r = {1'b1, 4'(c - 8'h30)};
    end else if (c >= "A" && c <= "F") begin
      r = {1'b1, 4'(c - 8'h37)};
    end
    return r;
  endfunction

endpackage

// File: rtl/exp_rom_if.sv
// HPS ioctl download stream plus the paced SDRAM write request it becomes.
interface exp_rom_if;

  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [31:0] ioctl_file_ext;
  logic        ioctl_wait;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [1:0]  boot_bank;
  logic [7:0]  boot_dout;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, ioctl_file_ext,
    input  ioctl_wait, boot_wr, boot_a, boot_bank, boot_dout
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, ioctl_file_ext,
    output ioctl_wait, boot_wr, boot_a, boot_bank, boot_dout
  );

endinterface

// File: rtl/exp_rom_loader_map.sv
// 256x1 expansion-ROM presence map. Only the power-up value clears it;
// reset deliberately leaves it alone so loaded ROMs survive a CPU reset.
module rom_presence_map (
  input  logic       clk_sys,
  input  logic       set_i,
  input  logic [7:0] set_addr_i,
  input  logic [7:0] query_addr_i,
  output logic       hit_o
);

  logic [255:0] map_q = '0;
  logic         hit_q;

  always_ff @(posedge clk_sys) begin
    if (set_i) begin
      map_q[set_addr_i] <= 1'b1;
    end
    hit_q <= map_q[query_addr_i];
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/exp_rom_loader.sv
// Turns the HPS ioctl byte stream into ce_ref-paced SDRAM writes for the boot
// image and .eXX expansion ROMs. Optional LOADER_CKSUM_EN adds a byte checksum.
module exp_rom_loader
  import exp_rom_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_ref,
  exp_rom_if.slave   bus,
  input  logic [7:0] map_addr,
  output logic       map_hit
`ifdef LOADER_CKSUM_EN
  ,
  output logic [15:0] cksum,
  output logic        cksum_valid
`endif
);

  localparam int unsigned SLOT_W = $clog2(BOOT_PAGES);

  state_e      state_q;
  logic        dl_q;
  logic [8:0]  page_q;
  logic        combo_q;
  logic        wait_q;
  logic        boot_wr_q;
  logic [22:0] boot_a_q;
  logic [1:0]  bank_q;
  logic [7:0]  dout_q;
  logic        dual_q;

  logic        dl_start;
  logic [4:0]  nib_hi, nib_lo;
  logic [8:0]  ext_page_d;
  logic        ext_combo_d;
  logic [10:0] slot;
  logic        boot_img, slot_ok, accept;
  logic [8:0]  slot_page;
  logic [7:0]  exp_pg;
  logic        unused_ext_hi;

  assign dl_start      = bus.ioctl_download & ~dl_q;
  assign unused_ext_hi = ^bus.ioctl_file_ext[31:16];

  // Each hex character overrides only its own nibble of BAD_PAGE
  always_comb begin
    nib_hi      = ext_char_to_nibble(bus.ioctl_file_ext[15:8]);
    nib_lo      = ext_char_to_nibble(bus.ioctl_file_ext[7:0]);
    ext_page_d  = BAD_PAGE;
    ext_combo_d = 1'b0;
    if (bus.ioctl_file_ext[15:0] == "ZZ") begin
      ext_page_d = '0;
    end else if (bus.ioctl_file_ext[15:0] == "Z0") begin
      ext_page_d  = '0;
      ext_combo_d = 1'b1;
    end else begin
      if (nib_hi[4]) ext_page_d[7:4] = nib_hi[3:0];
      if (nib_lo[4]) ext_page_d[3:0] = nib_lo[3:0];
      ext_page_d[8] = 1'b1;
    end
  end

  assign slot      = bus.ioctl_addr[24:14];
  assign boot_img  = (bus.ioctl_index == '0);
  assign slot_ok   = (slot < 11'(2 * BOOT_PAGES));
  assign slot_page = BOOT_SLOT_PAGE[slot[SLOT_W-1:0]];
  assign exp_pg    = page_q[7:0] + bus.ioctl_addr[21:14];
  assign accept    = (state_q == IDLE) && bus.ioctl_wr && bus.ioctl_download &&
                     (!boot_img || slot_ok);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      dl_q      <= 1'b0;
      page_q    <= BAD_PAGE;
      combo_q   <= 1'b0;
      wait_q    <= 1'b0;
      boot_wr_q <= 1'b0;
      boot_a_q  <= '0;
      bank_q    <= '0;
      dout_q    <= '0;
      dual_q    <= 1'b0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (dl_start) begin
        page_q  <= ext_page_d;
        combo_q <= ext_combo_d;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            dout_q  <= bus.ioctl_dout;
            wait_q  <= 1'b1;
            state_q <= PEND;
            if (boot_img) begin
              boot_a_q <= {slot_page, bus.ioctl_addr[13:0]};
              bank_q   <= {1'b0, slot[SLOT_W]};
              dual_q   <= 1'b0;
            end else begin
              boot_a_q <= {page_q[8], exp_pg, bus.ioctl_addr[13:0]};
              bank_q   <= {1'b0, bus.ioctl_index[7:6] == 2'b11};
              dual_q   <= (bus.ioctl_index[7:6] != 2'b11);
            end
          end
        end
        PEND: begin
          if (ce_ref) begin
            boot_wr_q <= 1'b1;
            state_q   <= WR0;
          end
        end
        WR0: begin
          // The request is consumed on this strobe; a dual load re-queues for bank 1
          if (ce_ref) begin
            boot_wr_q <= 1'b0;
            if (dual_q && bank_q == 2'd0) begin
              bank_q  <= 2'd1;
              state_q <= PEND;
            end else begin
              state_q <= WR1;
            end
          end
        end
        WR1: begin
          boot_wr_q <= 1'b0;
          wait_q    <= 1'b0;
          state_q   <= IDLE;
          if (combo_q && boot_a_q[13:0] == '1) begin
            page_q  <= MF2_PAGE;
            combo_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rom_presence_map u_map (
    .clk_sys      (clk_sys),
    .set_i        ((state_q == WR1) && boot_a_q[22]),
    .set_addr_i   (boot_a_q[21:14]),
    .query_addr_i (map_addr),
    .hit_o        (map_hit)
  );

  assign bus.ioctl_wait = wait_q;
  assign bus.boot_wr    = boot_wr_q;
  assign bus.boot_a     = boot_a_q;
  assign bus.boot_bank  = bank_q;
  assign bus.boot_dout  = dout_q;

`ifdef LOADER_CKSUM_EN
  logic [15:0] cksum_q;
  logic        cksum_valid_q;
  logic        end_pend_q;
  logic        dl_end;

  assign dl_end = ~bus.ioctl_download & dl_q;

  // A download end seen mid-write is held until the FSM is back in IDLE
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cksum_q       <= '0;
      cksum_valid_q <= 1'b0;
      end_pend_q    <= 1'b0;
    end else if (dl_start) begin
      cksum_q       <= '0;
      cksum_valid_q <= 1'b0;
      end_pend_q    <= 1'b0;
    end else begin
      if (accept) begin
        cksum_q <= cksum_q + 16'(bus.ioctl_dout);
      end
      if (dl_end || end_pend_q) begin
        if (state_q == IDLE) begin
          cksum_valid_q <= 1'b1;
          end_pend_q    <= 1'b0;
        end else begin
          end_pend_q <= 1'b1;
        end
      end
    end
  end

  assign cksum       = cksum_q;
  assign cksum_valid = cksum_valid_q;
`endif

endmodule
